// File: rtl/instr_fetch_decode.sv
// Instruction fetch responder: word-addressed instruction memory, IF/ID register
// and the branch/jump/immediate decode consumed by the PC.
module instr_fetch_decode #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [5:0]  OP_BEQ    = 6'h04,
    parameter logic [5:0]  OP_J      = 6'h02
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       direinstru,
    input  logic              stall,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       instru,
    output logic [31:0]       pc_id,
    output logic              valid_id,
    output logic              SaltoCond,
    output logic              Saltoincond,
    output logic [31:0]       extSigno,
    output logic              addr_fault,
    output logic [31:0]       fetch_count
);

    logic [31:0] mem [MEM_DEPTH];
    logic        in_range;
    logic [31:0] rdata;
    logic        squash;

    // Any address bit above the index field means the fetch is outside memory.
    assign in_range = (direinstru[31:ADDR_W] == '0);
    assign rdata    = in_range ? mem[direinstru[ADDR_W-1:0]] : NOP_WORD;

    // Program-load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instru      <= NOP_WORD;
            pc_id       <= '0;
            valid_id    <= 1'b0;
            squash      <= 1'b0;
            addr_fault  <= 1'b0;
            fetch_count <= '0;
        end else if (flush || squash) begin
            instru   <= NOP_WORD;
            pc_id    <= direinstru;
            valid_id <= 1'b0;
            squash   <= 1'b0;
        end else if (!stall) begin
            instru   <= rdata;
            pc_id    <= direinstru;
            valid_id <= in_range;
            // A jump leaving ID costs exactly one bubble on the following capture.
            squash   <= Saltoincond;
            if (in_range) begin
                fetch_count <= fetch_count + 32'd1;
            end else begin
                addr_fault <= 1'b1;
            end
        end
    end

    assign SaltoCond   = valid_id && (instru[31:26] == OP_BEQ);
    assign Saltoincond = valid_id && (instru[31:26] == OP_J);
    assign extSigno    = {{16{instru[15]}}, instru[15:0]};

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed fetch sequences push expected
// IF/ID state per edge, and a negedge monitor pops and compares.
module tb_instr_fetch_decode;

    logic        clk;
    logic        reset;
    logic [31:0] direinstru;
    logic        stall;
    logic        flush;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instru;
    logic [31:0] pc_id;
    logic        valid_id;
    logic        SaltoCond;
    logic        Saltoincond;
    logic [31:0] extSigno;
    logic        addr_fault;
    logic [31:0] fetch_count;

    instr_fetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .direinstru (direinstru),
        .stall      (stall),
        .flush      (flush),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .instru     (instru),
        .pc_id      (pc_id),
        .valid_id   (valid_id),
        .SaltoCond  (SaltoCond),
        .Saltoincond(Saltoincond),
        .extSigno   (extSigno),
        .addr_fault (addr_fault),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        v;
        logic        sc;
        logic        sj;
        logic [31:0] ext;
        logic        f;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          entry  = 0;
    logic [31:0] prog [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            entry++;
            chk("instru",      entry, instru,      e.ins);
            chk("pc_id",       entry, pc_id,       e.pc);
            chk("valid_id",    entry, {31'd0, valid_id},    {31'd0, e.v});
            chk("SaltoCond",   entry, {31'd0, SaltoCond},   {31'd0, e.sc});
            chk("Saltoincond", entry, {31'd0, Saltoincond}, {31'd0, e.sj});
            chk("extSigno",    entry, extSigno,    e.ext);
            chk("addr_fault",  entry, {31'd0, addr_fault},  {31'd0, e.f});
            chk("fetch_count", entry, fetch_count, e.cnt);
        end
    end

    task automatic drv(input logic [31:0] a, input logic st, input logic fl);
        direinstru = a;
        stall      = st;
        flush      = fl;
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic sc, input logic sj, input logic [31:0] ext,
                        input logic f, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        e.ins = ins; e.pc = pc; e.v = v; e.sc = sc; e.sj = sj;
        e.ext = ext; e.f = f; e.cnt = cnt;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h8C01_0000;
        prog[1] = 32'h1022_0003;
        prog[2] = 32'h0800_0010;
        prog[3] = 32'h0000_0000;
        prog[4] = 32'h1000_FFFE;
        prog[5] = 32'h0000_AAAA;
        prog[6] = 32'h2442_0001;
        prog[7] = 32'h2463_0002;
        prog[8] = 32'h0800_0020;
        prog[9] = 32'h2484_0003;

        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        drv(32'd0, 1'b0, 1'b0);

        // load program while in reset; every edge shows reset values
        for (int i = 0; i < 10; i++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = prog[i];
            step(32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'd0);
        end
        prog_we = 1'b0;
        reset   = 1'b0;

        // sequential fetch 0..3 with the jump at 2 squashing the target capture
        drv(32'd0, 0, 0); step(32'h8C01_0000, 32'd0, 1, 0, 0, 32'h0000_0000, 0, 32'd1);
        drv(32'd1, 0, 0); step(32'h1022_0003, 32'd1, 1, 1, 0, 32'h0000_0003, 0, 32'd2);
        drv(32'd2, 0, 0); step(32'h0800_0010, 32'd2, 1, 0, 1, 32'h0000_0010, 0, 32'd3);
        drv(32'd3, 0, 0); step(32'h0000_0000, 32'd3, 1, 0, 0, 32'h0000_0000, 0, 32'd4);
        drv(32'd6, 0, 0); step(32'h0000_0000, 32'd6, 0, 0, 0, 32'h0000_0000, 0, 32'd4);
        drv(32'd7, 0, 0); step(32'h2463_0002, 32'd7, 1, 0, 0, 32'h0000_0002, 0, 32'd5);

        // beq with negative offset, then flushed
        drv(32'd4, 0, 0); step(32'h1000_FFFE, 32'd4, 1, 1, 0, 32'hFFFF_FFFE, 0, 32'd6);
        drv(32'd5, 0, 1); step(32'h0000_0000, 32'd5, 0, 0, 0, 32'h0000_0000, 0, 32'd6);

        // jump held by stall; squash only once the stall drops, squash beats stall
        drv(32'd8, 0, 0); step(32'h0800_0020, 32'd8, 1, 0, 1, 32'h0000_0020, 0, 32'd7);
        drv(32'd9, 1, 0); step(32'h0800_0020, 32'd8, 1, 0, 1, 32'h0000_0020, 0, 32'd7);
        drv(32'd6, 1, 0); step(32'h0800_0020, 32'd8, 1, 0, 1, 32'h0000_0020, 0, 32'd7);
        drv(32'd9, 0, 0); step(32'h2484_0003, 32'd9, 1, 0, 0, 32'h0000_0003, 0, 32'd8);
        drv(32'd6, 1, 0); step(32'h0000_0000, 32'd6, 0, 0, 0, 32'h0000_0000, 0, 32'd8);
        drv(32'd7, 0, 0); step(32'h2463_0002, 32'd7, 1, 0, 0, 32'h0000_0002, 0, 32'd9);

        // three-cycle stall with a moving address, then stall+flush
        drv(32'd0, 1, 0); step(32'h2463_0002, 32'd7, 1, 0, 0, 32'h0000_0002, 0, 32'd9);
        drv(32'd1, 1, 0); step(32'h2463_0002, 32'd7, 1, 0, 0, 32'h0000_0002, 0, 32'd9);
        drv(32'd2, 1, 0); step(32'h2463_0002, 32'd7, 1, 0, 0, 32'h0000_0002, 0, 32'd9);
        drv(32'd3, 1, 1); step(32'h0000_0000, 32'd3, 0, 0, 0, 32'h0000_0000, 0, 32'd9);

        // out-of-range fetches set a sticky fault
        drv(32'd256, 0, 0);        step(32'h0000_0000, 32'd256,        0, 0, 0, 32'h0, 1, 32'd9);
        drv(32'd0, 0, 0);          step(32'h8C01_0000, 32'd0,          1, 0, 0, 32'h0, 1, 32'd10);
        drv(32'h8000_0001, 0, 0);  step(32'h0000_0000, 32'h8000_0001,  0, 0, 0, 32'h0, 1, 32'd10);

        // write and fetch the same word in one cycle: old word first, new word next
        prog_we = 1'b1; prog_addr = 8'd5; prog_data = 32'h0000_BBBB;
        drv(32'd5, 0, 0); step(32'h0000_AAAA, 32'd5, 1, 0, 0, 32'hFFFF_AAAA, 1, 32'd11);
        prog_we = 1'b0;
        drv(32'd5, 0, 0); step(32'h0000_BBBB, 32'd5, 1, 0, 0, 32'hFFFF_BBBB, 1, 32'd12);

        // reset with a squash pending: no bubble after reset, fault cleared
        drv(32'd2, 0, 0); step(32'h0800_0010, 32'd2, 1, 0, 1, 32'h0000_0010, 1, 32'd13);
        drv(32'd3, 0, 0); step(32'h0000_0000, 32'd3, 1, 0, 0, 32'h0000_0000, 1, 32'd14);
        reset = 1'b1;
        drv(32'd6, 0, 0); step(32'h0000_0000, 32'd0, 0, 0, 0, 32'h0000_0000, 0, 32'd0);
        reset = 1'b0;
        drv(32'd6, 0, 0); step(32'h2442_0001, 32'd6, 1, 0, 0, 32'h0000_0001, 0, 32'd1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", entry, 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Responder side of the instruction-fetch interface driven by the program counter: accepts the word address `direinstru` and returns the instruction word.
- Holds the word-addressed instruction memory with a program-load write port and the IF/ID pipeline register.
- Decodes the registered instruction into the control and immediate signals the PC consumes: `SaltoCond`, `Saltoincond`, `extSigno`, `instru`.
- Sits between the PC and the decode/register-file stage of the segmented processor.

Parameters:
- MEM_DEPTH, 256, number of 32-bit instruction words.
- ADDR_W, 8, address bits used to index memory; log2(MEM_DEPTH).
- NOP_WORD, 32'h0000_0000, word injected for bubbles and out-of-range fetches.
- OP_BEQ, 6'h04, opcode decoded as a conditional branch.
- OP_J, 6'h02, opcode decoded as an unconditional jump.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- direinstru  in  32  fetch word address from the PC.
- stall  in  1  hold the IF/ID register (hazard unit).
- flush  in  1  replace the next IF/ID capture with a bubble.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_W  program-load word address.
- prog_data  in  32  program-load data.
- instru  out  32  registered instruction (IF/ID).
- pc_id  out  32  fetch address of the instruction held in `instru`.
- valid_id  out  1  `instru` is a real instruction, not a bubble.
- SaltoCond  out  1  ID instruction is `beq`.
- Saltoincond  out  1  ID instruction is `j`.
- extSigno  out  32  sign-extended `instru[15:0]`, word offset, not shifted.
- addr_fault  out  1  sticky: a fetch address was >= MEM_DEPTH.
- fetch_count  out  32  number of valid instructions captured into IF/ID.

Behaviour:

Memory read and write
- Read is combinational: rdata = mem[direinstru[ADDR_W-1:0]].
- If direinstru >= MEM_DEPTH, i.e. any bit above ADDR_W-1 is set, rdata = NOP_WORD and the capture is invalid.
- Write is synchronous: prog_we=1 writes prog_data to mem[prog_addr] at the clock edge.
- A read of the same address in the same cycle returns the old word.
- Memory contents are not cleared by reset.

IF/ID register, evaluated per rising edge in priority order
1. reset=1: instru=NOP_WORD, pc_id=0, valid_id=0, squash=0, addr_fault=0, fetch_count=0.
2. flush=1 or squash=1: instru=NOP_WORD, valid_id=0, pc_id=direinstru, squash cleared. Flush wins over stall.
3. stall=1: instru, pc_id and valid_id hold.
4. Otherwise: instru=rdata, pc_id=direinstru, valid_id = (direinstru < MEM_DEPTH).

Counters and flags
- fetch_count increments by 1 on any edge in which case 4 captures with valid_id becoming 1.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- addr_fault is set by case 4 with an out-of-range address and stays set until reset.

Internal squash flag
- Set on the edge where valid_id=1, Saltoincond=1 and stall=0. The jump redirects the PC at that same edge.
- While set, the following capture is turned into a bubble (case 2).
- A taken-jump penalty is exactly 1 bubble.
- Taken conditional branches are squashed through the external `flush`.

Decode (combinational from registered state)
- SaltoCond = valid_id & (instru[31:26]==OP_BEQ).
- Saltoincond = valid_id & (instru[31:26]==OP_J).
- A bubble never asserts either output.
- extSigno = {{16{instru[15]}}, instru[15:0]}, also driven for bubbles.

Latency and timing
- An instruction fetched at edge N appears on `instru` and the decode outputs after edge N, and is consumed by the PC at edge N+1.

Test Plan:
- Load mem[0..3] = {8C010000, 10220003, 08000010, 00000000}, reset 2 cycles, drive direinstru 0,1,2,3 → `instru` shows each word one cycle later; after reset `valid_id`=0 and `fetch_count`=0; `fetch_count` reaches 4; SaltoCond=1 only while 10220003 is held; extSigno=32'h0000_0003.
- beq with imm 16'hFFFE → extSigno=32'hFFFF_FFFE, SaltoCond=1; with flush=1 on the next edge → `instru`=0, `valid_id`=0, SaltoCond=0.
- j 08000010 in ID with stall=0 → next capture is a bubble (valid_id=0, Saltoincond=0), the capture after it is valid, fetch_count +1 only for the valid one; same case with stall=1 for 2 cycles → jump held and no squash until stall drops.
- stall=1 for 3 cycles with direinstru changing → instru/pc_id/valid_id/fetch_count hold; stall=1 with flush=1 → bubble captured.
- direinstru=256 (MEM_DEPTH=256) → instru=0, valid_id=0, addr_fault=1 and stays 1 afterwards; addr_fault clears only on reset.
- prog_we=1 to address 5 while direinstru=5 → same-cycle capture gets old word, next capture gets new word; reset asserted mid-stream with a pending squash → all outputs at reset values, no bubble after reset.
